// File: rtl/lfsr.sv
// Fibonacci LFSR producing one pseudo-random bit per clock. Two instances XOR-ed
// together form a 3GPP Gold sequence. Taps and seed come from parameters, or can be
// reloaded at run time when VARIABLE_CONFIG is set.
module lfsr #(
  parameter int unsigned    N               = 31,
  parameter logic [N-1:0]   TAPS            = N'(9),
  parameter logic [N-1:0]   START_VALUE     = N'(1),
  parameter bit             VARIABLE_CONFIG = 1'b0
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         load_config_i,
  input  logic [N-1:0] taps_i,
  input  logic [N-1:0] start_value_i,
  output logic         data_o,
  output logic         valid_o
);

  // s[0] is the oldest bit x(n); s[N-1] is x(n+N-1).
  logic [N-1:0] state_q, state_d;
  logic [N-1:0] taps_q;
  logic         valid_q, valid_d;
  logic         load_en;
  logic         feedback;

  if (VARIABLE_CONFIG) begin : g_var_cfg
    logic [N-1:0] taps_d;

    assign load_en = load_config_i;

    // Taps reload: reset restores the parameter, a load strobe takes the input.
    always_comb begin
      taps_d = taps_q;
      if (!reset_ni) begin
        taps_d = TAPS;
      end else if (load_en) begin
        taps_d = taps_i;
      end
    end

    // Taps register.
    always_ff @(posedge clk_i) begin
      taps_q <= taps_d;
    end
  end else begin : g_fixed_cfg
    logic unused_cfg;

    // Config inputs are ignored entirely in the fixed build.
    assign load_en    = 1'b0;
    assign taps_q     = TAPS;
    assign unused_cfg = ^{load_config_i, taps_i};
  end

  assign feedback = ^(state_q & taps_q);

  // Next state: reset beats load; the first edge out of reset (or a load) only
  // raises valid so x(0) is presented for a full cycle before shifting starts.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    if (!reset_ni) begin
      state_d = START_VALUE;
      valid_d = 1'b0;
    end else if (load_en) begin
      state_d = start_value_i;
      valid_d = 1'b1;
    end else if (!valid_q) begin
      valid_d = 1'b1;
    end else begin
      state_d = {feedback, state_q[N-1:1]};
    end
  end

  // State and valid registers, synchronous active-low reset handled above.
  always_ff @(posedge clk_i) begin
    state_q <= state_d;
    valid_q <= valid_d;
  end

  assign data_o  = state_q[0];
  assign valid_o = valid_q;

endmodule

// File: tb/tb_lfsr.sv
// Bench for lfsr: five instances (N=5, 3GPP x1, run-time x2, fixed x2, zero seed)
// share clock, reset and config inputs; each cycle's expected outputs are queued
// when inputs are driven and checked on the following falling edge.
module tb_lfsr;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        load;
  logic [30:0] cfg_taps;
  logic [30:0] cfg_seed;
  logic [4:0]  d_o;
  logic [4:0]  v_o;

  always #5 clk_i = ~clk_i;

  lfsr #(.N(5), .TAPS(5'h05), .START_VALUE(5'd1), .VARIABLE_CONFIG(1'b0)) u_n5 (
    .clk_i(clk_i), .reset_ni(rst_n), .load_config_i(load), .taps_i(cfg_taps[4:0]),
    .start_value_i(cfg_seed[4:0]), .data_o(d_o[0]), .valid_o(v_o[0]));

  lfsr #(.N(31), .TAPS(31'h9), .START_VALUE(31'd1), .VARIABLE_CONFIG(1'b0)) u_x1 (
    .clk_i(clk_i), .reset_ni(rst_n), .load_config_i(load), .taps_i(cfg_taps),
    .start_value_i(cfg_seed), .data_o(d_o[1]), .valid_o(v_o[1]));

  lfsr #(.N(31), .TAPS(31'h9), .START_VALUE(31'd1), .VARIABLE_CONFIG(1'b1)) u_x2 (
    .clk_i(clk_i), .reset_ni(rst_n), .load_config_i(load), .taps_i(cfg_taps),
    .start_value_i(cfg_seed), .data_o(d_o[2]), .valid_o(v_o[2]));

  lfsr #(.N(31), .TAPS(31'hF), .START_VALUE(31'h2), .VARIABLE_CONFIG(1'b0)) u_x2f (
    .clk_i(clk_i), .reset_ni(rst_n), .load_config_i(load), .taps_i(cfg_taps),
    .start_value_i(cfg_seed), .data_o(d_o[3]), .valid_o(v_o[3]));

  lfsr #(.N(8), .TAPS(8'h8E), .START_VALUE(8'h00), .VARIABLE_CONFIG(1'b0)) u_z (
    .clk_i(clk_i), .reset_ni(rst_n), .load_config_i(load), .taps_i(cfg_taps[7:0]),
    .start_value_i(cfg_seed[7:0]), .data_o(d_o[4]), .valid_o(v_o[4]));

  typedef struct packed {
    logic       v;
    logic [4:0] d;  // {z, x2f, x2, x1, n5}
  } exp_t;

  typedef struct packed {
    bit   rn;
    bit   ld;
    exp_t e;
  } vec_t;

  exp_t  sb_q[$];
  vec_t  tab[12];
  string nm[5];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  // Reference model state, one slot per instance.
  int          m_n[5];
  logic [63:0] m_seed[5];
  logic [63:0] m_taps0[5];
  logic [63:0] m_s[5];
  logic [63:0] m_tp[5];
  bit          m_vc[5];
  bit          m_v = 1'b0;

  function automatic void check(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_edge(bit rn, bit ld, logic [30:0] tp, logic [30:0] sv);
    for (int i = 0; i < 5; i++) begin
      logic [63:0] mask;
      logic        f;
      mask = (64'd1 << m_n[i]) - 64'd1;
      if (!rn) begin
        m_s[i]  = m_seed[i];
        m_tp[i] = m_taps0[i];
      end else if (m_vc[i] && ld) begin
        m_s[i]  = {33'd0, sv} & mask;
        m_tp[i] = {33'd0, tp} & mask;
      end else if (m_v) begin
        f       = ^(m_s[i] & m_tp[i]);
        m_s[i]  = (m_s[i] >> 1) | ({63'd0, f} << (m_n[i] - 1));
      end
    end
    m_v = rn;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.v = m_v;
    for (int i = 0; i < 5; i++) e.d[i] = m_s[i][0];
    return e;
  endfunction

  // One clock: drive inputs, queue the expectation, check after the edge.
  task automatic step(input bit rn, input bit ld, input logic [30:0] tp,
                      input logic [30:0] sv, input bit use_tab, input exp_t te);
    exp_t e;
    rst_n    = rn;
    load     = ld;
    cfg_taps = tp;
    cfg_seed = sv;
    model_edge(rn, ld, tp, sv);
    sb_q.push_back(use_tab ? te : model_exp());
    @(posedge clk_i);
    @(negedge clk_i);
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      check({nm[i], " data"}, d_o[i], e.d[i]);
      check({nm[i], " valid"}, v_o[i], e.v);
    end
    cyc++;
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      step(1'b1, 1'b0, 31'($urandom), 31'($urandom), 1'b0, '0);
    end
  endtask

  initial begin
    nm[0] = "n5"; nm[1] = "x1"; nm[2] = "x2"; nm[3] = "x2f"; nm[4] = "zero";
    m_n[0] = 5;  m_seed[0] = 64'd1; m_taps0[0] = 64'h05; m_vc[0] = 1'b0;
    m_n[1] = 31; m_seed[1] = 64'd1; m_taps0[1] = 64'h09; m_vc[1] = 1'b0;
    m_n[2] = 31; m_seed[2] = 64'd1; m_taps0[2] = 64'h09; m_vc[2] = 1'b1;
    m_n[3] = 31; m_seed[3] = 64'h2; m_taps0[3] = 64'h0F; m_vc[3] = 1'b0;
    m_n[4] = 8;  m_seed[4] = 64'h0; m_taps0[4] = 64'h8E; m_vc[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_s[i]  = '0;
      m_tp[i] = '0;
    end

    // Release with load on the same edge: n5 gives 1,0,0,0,0,1,0,0,1,0,1; x1 gives
    // 1,0,0..; loaded x2 (seed 2) and fixed x2 stay aligned at 0,1,0,...
    tab[0]  = '{rn: 1'b0, ld: 1'b0, e: '{v: 1'b0, d: 5'b00111}};
    tab[1]  = '{rn: 1'b1, ld: 1'b1, e: '{v: 1'b1, d: 5'b00011}};
    tab[2]  = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b01100}};
    tab[3]  = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b00000}};
    tab[4]  = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b00000}};
    tab[5]  = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b00000}};
    tab[6]  = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b00001}};
    tab[7]  = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b00000}};
    tab[8]  = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b00000}};
    tab[9]  = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b00001}};
    tab[10] = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b00000}};
    tab[11] = '{rn: 1'b1, ld: 1'b0, e: '{v: 1'b1, d: 5'b00001}};

    // Power-up reset.
    step(1'b0, 1'b0, 31'h0, 31'h0, 1'b0, '0);
    step(1'b0, 1'b0, 31'h0, 31'h0, 1'b0, '0);

    foreach (tab[j]) begin
      step(tab[j].rn, tab[j].ld, 31'hF, 31'h2, 1'b1, tab[j].e);
    end

    // Run past x(50); x1 passes x(31) and x(34), n5 wraps its period of 31.
    run(40);

    // Mid-run reload of x2 with seed 1; fixed instances must ignore the strobe.
    step(1'b1, 1'b1, 31'hF, 31'h1, 1'b0, '0);
    check("reload x0", d_o[2], 1'b1);
    run(40);

    // Reset together with load: reset wins, data shows each START_VALUE[0].
    step(1'b0, 1'b1, 31'hF, 31'h2, 1'b0, '0);
    check("reset+load valid", v_o[2], 1'b0);
    check("reset+load data", d_o[2], 1'b1);
    step(1'b0, 1'b0, 31'h0, 31'h0, 1'b0, '0);

    // Plain release: sequences restart from the parameter seeds.
    step(1'b1, 1'b0, 31'h0, 31'h0, 1'b0, '0);
    check("restart n5 x0", d_o[0], 1'b1);
    check("restart x2 x0", d_o[2], 1'b1);
    run(70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
